// File: rtl/vga_rx_monitor.sv
// Receive-side VGA timing checker: recovers line/frame timing from sampled syncs,
// measures periods and widths, signs the active region and tracks lock.
module vga_rx_monitor #(
    parameter int unsigned H_TOTAL         = 800,
    parameter int unsigned V_TOTAL         = 525,
    parameter int unsigned HS_WIDTH        = 96,
    parameter int unsigned VS_WIDTH        = 2,
    parameter int unsigned H_ACT_START     = 144,
    parameter int unsigned V_ACT_START     = 35,
    parameter int unsigned H_ACTIVE        = 640,
    parameter int unsigned V_ACTIVE        = 480,
    parameter int unsigned SYNC_ACTIVE_LOW = 1,
    parameter int unsigned STALL_CYCLES    = 1024
) (
    input  logic        clk50,
    input  logic        rst_n,
    input  logic        pix_clk_in,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic [2:0]  vga_r,
    input  logic [2:0]  vga_g,
    input  logic [1:0]  vga_b,
    output logic        locked,
    output logic        frame_done,
    output logic [15:0] frame_crc,
    output logic [9:0]  meas_h_total,
    output logic [9:0]  meas_v_total,
    output logic [9:0]  meas_hs_width,
    output logic [9:0]  meas_vs_width,
    output logic [7:0]  frame_count,
    output logic        timing_err,
    output logic [7:0]  err_count
);

    localparam int unsigned CW = 10;
    localparam int unsigned SW = $clog2(STALL_CYCLES + 1);

    localparam logic [CW-1:0] H_TOT    = CW'(H_TOTAL);
    localparam logic [CW-1:0] V_TOT    = CW'(V_TOTAL);
    localparam logic [CW-1:0] HS_W     = CW'(HS_WIDTH);
    localparam logic [CW-1:0] VS_W     = CW'(VS_WIDTH);
    localparam logic [CW-1:0] H_ACT_LO = CW'(H_ACT_START);
    localparam logic [CW-1:0] H_ACT_HI = CW'(H_ACT_START + H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_LO = CW'(V_ACT_START);
    localparam logic [CW-1:0] V_ACT_HI = CW'(V_ACT_START + V_ACTIVE);
    localparam logic [SW-1:0] STALL_M1 = SW'(STALL_CYCLES - 1);
    localparam logic [SW-1:0] STALL_MX = SW'(STALL_CYCLES);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
        return (x == '1) ? x : x + CW'(1);
    endfunction

    state_t          state_q, state_nxt;
    logic            pclk_q;
    logic            hs_q, vs_q;
    logic [CW-1:0]   h_cnt, v_cnt, hs_w, vs_w;
    logic [15:0]     chk;
    logic [SW-1:0]   stall_cnt;
    logic            frame_bad_q, frame_bad_nxt;
    logic            skip_q, skip_nxt;
    logic            done_nxt;

    logic            pix_en, hs_a, vs_a;
    logic            hs_lead, hs_trail, vs_lead, vs_trail;
    logic [CW-1:0]   h_nxt, v_nxt, h_plus1, v_plus1;
    logic            active, chk_en, line_err, frame_err, any_err, stall_hit;

    // Pixel strobe and sync decode
    assign pix_en   = pix_clk_in & ~pclk_q;
    assign hs_a     = (SYNC_ACTIVE_LOW != 0) ? ~vga_hs : vga_hs;
    assign vs_a     = (SYNC_ACTIVE_LOW != 0) ? ~vga_vs : vga_vs;
    assign hs_lead  = pix_en &  hs_a & ~hs_q;
    assign hs_trail = pix_en & ~hs_a &  hs_q;
    assign vs_lead  = pix_en &  vs_a & ~vs_q;
    assign vs_trail = pix_en & ~vs_a &  vs_q;

    // Position of the current sample; the window test uses the value this sample takes
    assign h_plus1 = sat_inc(h_cnt);
    assign v_plus1 = sat_inc(v_cnt);
    assign h_nxt   = hs_lead ? '0 : h_plus1;
    assign v_nxt   = vs_lead ? '0 : (hs_lead ? v_plus1 : v_cnt);
    assign active  = (h_nxt >= H_ACT_LO) && (h_nxt < H_ACT_HI) &&
                     (v_nxt >= V_ACT_LO) && (v_nxt < V_ACT_HI);

    assign chk_en    = (state_q != ST_SEARCH);
    assign line_err  = chk_en & ~skip_q &
                       ((hs_lead & (h_plus1 != H_TOT)) | (hs_trail & (hs_w != HS_W)));
    assign frame_err = chk_en &
                       ((vs_lead & (v_plus1 != V_TOT)) | (vs_trail & (vs_w != VS_W)));
    assign any_err   = line_err | frame_err;
    assign stall_hit = ~pix_en & (stall_cnt >= STALL_M1);

    // State register
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) state_q <= ST_SEARCH;
        else        state_q <= state_nxt;
    end

    // Next state, frame_done, frame_bad and first-edge skip
    always_comb begin
        state_nxt     = state_q;
        done_nxt      = 1'b0;
        frame_bad_nxt = frame_bad_q | any_err;
        skip_nxt      = skip_q;
        if (vs_lead) begin
            frame_bad_nxt = 1'b0;
            case (state_q)
                ST_SEARCH:  state_nxt = ST_MEASURE;
                ST_MEASURE: begin
                    done_nxt = 1'b1;
                    if (!frame_bad_q && !any_err) state_nxt = ST_LOCKED;
                end
                ST_LOCKED: begin
                    done_nxt = 1'b1;
                    if (any_err) state_nxt = ST_MEASURE;
                end
                default: state_nxt = ST_SEARCH;
            endcase
        end else if (any_err && state_q == ST_LOCKED) begin
            state_nxt = ST_MEASURE;
        end
        if (stall_hit) begin
            state_nxt = ST_SEARCH;
            done_nxt  = 1'b0;
        end
        if (state_nxt == ST_SEARCH)
            skip_nxt = 1'b1;
        else if (chk_en && (hs_lead || hs_trail))
            skip_nxt = 1'b0;
    end

    // Control and status outputs
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            pclk_q      <= 1'b0;
            stall_cnt   <= '0;
            frame_bad_q <= 1'b0;
            skip_q      <= 1'b1;
            locked      <= 1'b0;
            frame_done  <= 1'b0;
            timing_err  <= 1'b0;
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            pclk_q      <= pix_clk_in;
            frame_bad_q <= frame_bad_nxt;
            skip_q      <= skip_nxt;
            locked      <= (state_nxt == ST_LOCKED);
            frame_done  <= done_nxt;
            timing_err  <= any_err;
            if (pix_en)
                stall_cnt <= '0;
            else if (stall_cnt != STALL_MX)
                stall_cnt <= stall_cnt + SW'(1);
            if (done_nxt)
                frame_count <= frame_count + 8'd1;
            if (any_err && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

    // Timing counters, measurements and signature, advanced once per pixel sample
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            h_cnt         <= '0;
            v_cnt         <= '0;
            hs_w          <= '0;
            vs_w          <= '0;
            chk           <= '0;
            frame_crc     <= '0;
            meas_h_total  <= '0;
            meas_v_total  <= '0;
            meas_hs_width <= '0;
            meas_vs_width <= '0;
        end else if (pix_en) begin
            hs_q  <= hs_a;
            vs_q  <= vs_a;
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
            if (hs_a)
                hs_w <= hs_lead ? CW'(1) : sat_inc(hs_w);
            if (vs_a) begin
                if (vs_lead)
                    vs_w <= hs_lead ? CW'(1) : '0;
                else if (hs_lead)
                    vs_w <= sat_inc(vs_w);
            end
            if (hs_lead)  meas_h_total  <= h_plus1;
            if (hs_trail) meas_hs_width <= hs_w;
            if (vs_trail) meas_vs_width <= vs_w;
            if (vs_lead) begin
                meas_v_total <= v_plus1;
                frame_crc    <= chk;
                chk          <= '0;
            end else if (active) begin
                chk <= {chk[14:0], chk[15]} ^ {8'h00, vga_r, vga_g, vga_b};
            end
        end
    end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor on a scaled-down raster (40x20 total, 24x12 active).
module tb_vga_rx_monitor;

    localparam int HT  = 40;
    localparam int VT  = 20;
    localparam int HSW = 6;
    localparam int VSW = 2;
    localparam int HAS = 10;
    localparam int VAS = 4;
    localparam int HA  = 24;
    localparam int VA  = 12;

    logic       clk50 = 1'b0;
    logic       rst_n = 1'b1;
    logic       pix_clk_in = 1'b0;
    logic       hs_n = 1'b1, vs_n = 1'b1;   // active-low syncs
    logic       hs_p = 1'b0, vs_p = 1'b0;   // active-high syncs
    logic [7:0] pix_rgb = 8'h00;

    logic        a_locked, a_frame_done, a_timing_err;
    logic [15:0] a_frame_crc;
    logic [9:0]  a_meas_h_total, a_meas_v_total, a_meas_hs_width, a_meas_vs_width;
    logic [7:0]  a_frame_count, a_err_count;

    logic        b_locked, b_frame_done, b_timing_err;
    logic [15:0] b_frame_crc;
    logic [9:0]  b_meas_h_total, b_meas_v_total, b_meas_hs_width, b_meas_vs_width;
    logic [7:0]  b_frame_count, b_err_count;

    int tests_run = 0;
    int tests_failed = 0;

    int tb_h = 0, tb_v = 0;
    int long_v = -1;
    int hot_h = -1, hot_v = -1;
    logic [7:0] hot_rgb = 8'h00;

    always #10 clk50 = ~clk50;

    vga_rx_monitor #(
        .H_TOTAL(HT), .V_TOTAL(VT), .HS_WIDTH(HSW), .VS_WIDTH(VSW),
        .H_ACT_START(HAS), .V_ACT_START(VAS), .H_ACTIVE(HA), .V_ACTIVE(VA),
        .SYNC_ACTIVE_LOW(1), .STALL_CYCLES(1024)
    ) dut_a (
        .clk50(clk50), .rst_n(rst_n), .pix_clk_in(pix_clk_in),
        .vga_hs(hs_n), .vga_vs(vs_n),
        .vga_r(pix_rgb[7:5]), .vga_g(pix_rgb[4:2]), .vga_b(pix_rgb[1:0]),
        .locked(a_locked), .frame_done(a_frame_done), .frame_crc(a_frame_crc),
        .meas_h_total(a_meas_h_total), .meas_v_total(a_meas_v_total),
        .meas_hs_width(a_meas_hs_width), .meas_vs_width(a_meas_vs_width),
        .frame_count(a_frame_count), .timing_err(a_timing_err), .err_count(a_err_count)
    );

    vga_rx_monitor #(
        .H_TOTAL(HT), .V_TOTAL(VT), .HS_WIDTH(HSW), .VS_WIDTH(VSW),
        .H_ACT_START(HAS), .V_ACT_START(VAS), .H_ACTIVE(HA), .V_ACTIVE(VA),
        .SYNC_ACTIVE_LOW(0), .STALL_CYCLES(1024)
    ) dut_b (
        .clk50(clk50), .rst_n(rst_n), .pix_clk_in(pix_clk_in),
        .vga_hs(hs_p), .vga_vs(vs_p),
        .vga_r(pix_rgb[7:5]), .vga_g(pix_rgb[4:2]), .vga_b(pix_rgb[1:0]),
        .locked(b_locked), .frame_done(b_frame_done), .frame_crc(b_frame_crc),
        .meas_h_total(b_meas_h_total), .meas_v_total(b_meas_v_total),
        .meas_hs_width(b_meas_hs_width), .meas_vs_width(b_meas_vs_width),
        .frame_count(b_frame_count), .timing_err(b_timing_err), .err_count(b_err_count)
    );

    // One pixel over two clk50 cycles; returns at the negedge after the strobe edge
    task automatic step_pixel();
        logic hs_as, vs_as;
        int   len;
        hs_as = (tb_h < HSW);
        vs_as = (tb_v < VSW);
        @(negedge clk50);
        pix_clk_in = 1'b1;
        hs_n = ~hs_as; vs_n = ~vs_as;
        hs_p =  hs_as; vs_p =  vs_as;
        pix_rgb = (tb_h == hot_h && tb_v == hot_v) ? hot_rgb : 8'h00;
        @(negedge clk50);
        pix_clk_in = 1'b0;
        len = (tb_v == long_v) ? HT + 1 : HT;
        tb_h++;
        if (tb_h >= len) begin
            tb_h = 0;
            tb_v++;
            if (tb_v >= VT) tb_v = 0;
        end
    endtask

    // Drive until k frame starts (vs leading edges) have been sent
    task automatic run_vs(input int k);
        int n;
        n = 0;
        while (n < k) begin
            if (tb_h == 0 && tb_v == 0) n++;
            step_pixel();
        end
    endtask

    task automatic run_until(input int h, input int v);
        int lh, lv;
        do begin
            lh = tb_h; lv = tb_v;
            step_pixel();
        end while (!(lh == h && lv == v));
    endtask

    task automatic do_reset();
        @(negedge clk50);
        rst_n = 1'b0;
        pix_clk_in = 1'b0;
        hs_n = 1'b1; vs_n = 1'b1; hs_p = 1'b0; vs_p = 1'b0;
        pix_rgb = 8'h00;
        repeat (3) @(negedge clk50);
        rst_n = 1'b1;
        tb_h = 0; tb_v = 0; long_v = -1; hot_h = -1; hot_v = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #5;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (a_locked !== 1'b0 || a_frame_done !== 1'b0 || a_timing_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got locked=%b done=%b err=%b expected 0 0 0",
                     a_locked, a_frame_done, a_timing_err);
        end
        tests_run++;
        if (a_frame_count !== 8'd0 || a_err_count !== 8'd0 || a_frame_crc !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_counts: got fc=%0d ec=%0d crc=%h expected 0 0 0000",
                     a_frame_count, a_err_count, a_frame_crc);
        end
        tests_run++;
        if (a_meas_h_total !== 10'd0 || a_meas_v_total !== 10'd0 ||
            a_meas_hs_width !== 10'd0 || a_meas_vs_width !== 10'd0) begin
            tests_failed++;
            $display("FAIL reset_meas: got %0d %0d %0d %0d expected 0 0 0 0",
                     a_meas_h_total, a_meas_v_total, a_meas_hs_width, a_meas_vs_width);
        end
        repeat (3) @(negedge clk50);
        rst_n = 1'b1;
    endtask

    task automatic test_nominal();
        do_reset();
        run_vs(1);
        tests_run++;
        if (a_locked !== 1'b0 || a_frame_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL nominal_first_vs: got locked=%b done=%b expected 0 0", a_locked, a_frame_done);
        end
        run_vs(1);
        tests_run++;
        if (a_locked !== 1'b1 || a_frame_done !== 1'b1 || a_frame_count !== 8'd1) begin
            tests_failed++;
            $display("FAIL nominal_second_vs: got locked=%b done=%b fc=%0d expected 1 1 1",
                     a_locked, a_frame_done, a_frame_count);
        end
        run_vs(1);
        tests_run++;
        if (a_locked !== 1'b1 || a_frame_count !== 8'd2) begin
            tests_failed++;
            $display("FAIL nominal_third_vs: got locked=%b fc=%0d expected 1 2", a_locked, a_frame_count);
        end
        tests_run++;
        if (a_meas_h_total !== 10'(HT) || a_meas_v_total !== 10'(VT)) begin
            tests_failed++;
            $display("FAIL nominal_periods: got h=%0d v=%0d expected %0d %0d",
                     a_meas_h_total, a_meas_v_total, HT, VT);
        end
        tests_run++;
        if (a_meas_hs_width !== 10'(HSW) || a_meas_vs_width !== 10'(VSW)) begin
            tests_failed++;
            $display("FAIL nominal_widths: got hs=%0d vs=%0d expected %0d %0d",
                     a_meas_hs_width, a_meas_vs_width, HSW, VSW);
        end
        tests_run++;
        if (a_frame_crc !== 16'h0000 || a_err_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL nominal_crc_err: got crc=%h ec=%0d expected 0000 0", a_frame_crc, a_err_count);
        end
    endtask

    task automatic test_signature();
        int          th [7] = '{HAS,   HAS+HA-1, HAS+HA-2, HAS-1, HAS+HA,   HAS,   HAS};
        int          tv [7] = '{VAS,   VAS+VA-1, VAS+VA-1, VAS,   VAS+VA-1, VAS-1, VAS+VA};
        logic [7:0]  tc [7] = '{8'hFF, 8'hFF,    8'h5A,    8'hFF, 8'hFF,    8'hFF, 8'hFF};
        logic [15:0] te [7] = '{16'h807F, 16'h00FF, 16'h00B4, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        for (int i = 0; i < 7; i++) begin
            hot_h = th[i]; hot_v = tv[i]; hot_rgb = tc[i];
            run_vs(1);
            tests_run++;
            if (a_frame_crc !== te[i] || a_frame_done !== 1'b1) begin
                tests_failed++;
                $display("FAIL signature_%0d (%0d,%0d): got crc=%h done=%b expected %h 1",
                         i, th[i], tv[i], a_frame_crc, a_frame_done, te[i]);
            end
        end
        hot_h = -1; hot_v = -1;
    endtask

    task automatic test_long_line();
        long_v = 5;
        run_until(0, 6);
        long_v = -1;
        tests_run++;
        if (a_timing_err !== 1'b1 || a_locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL long_line_err: got err=%b locked=%b expected 1 0", a_timing_err, a_locked);
        end
        tests_run++;
        if (a_err_count !== 8'd1 || a_meas_h_total !== 10'(HT + 1)) begin
            tests_failed++;
            $display("FAIL long_line_meas: got ec=%0d h=%0d expected 1 %0d",
                     a_err_count, a_meas_h_total, HT + 1);
        end
        step_pixel();
        tests_run++;
        if (a_timing_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL long_line_pulse: got err=%b expected 0", a_timing_err);
        end
        run_vs(1);
        tests_run++;
        if (a_locked !== 1'b0 || a_frame_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL long_line_bad_frame: got locked=%b done=%b expected 0 1", a_locked, a_frame_done);
        end
        run_vs(1);
        tests_run++;
        if (a_locked !== 1'b1 || a_err_count !== 8'd1 || a_meas_h_total !== 10'(HT)) begin
            tests_failed++;
            $display("FAIL long_line_relock: got locked=%b ec=%0d h=%0d expected 1 1 %0d",
                     a_locked, a_err_count, a_meas_h_total, HT);
        end
    endtask

    task automatic test_stall();
        logic seen_done;
        seen_done = 1'b0;
        run_until(20, 8);
        repeat (1000) begin
            @(negedge clk50);
            if (a_frame_done) seen_done = 1'b1;
        end
        tests_run++;
        if (a_locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_short: got locked=%b expected 1", a_locked);
        end
        repeat (30) begin
            @(negedge clk50);
            if (a_frame_done) seen_done = 1'b1;
        end
        tests_run++;
        if (a_locked !== 1'b0 || seen_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_lost: got locked=%b done_seen=%b expected 0 0", a_locked, seen_done);
        end
        run_vs(1);
        tests_run++;
        if (a_locked !== 1'b0 || a_frame_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_search_exit: got locked=%b done=%b expected 0 0", a_locked, a_frame_done);
        end
        run_vs(1);
        tests_run++;
        if (a_locked !== 1'b1 || a_frame_done !== 1'b1 || a_err_count !== 8'd1) begin
            tests_failed++;
            $display("FAIL stall_relock: got locked=%b done=%b ec=%0d expected 1 1 1",
                     a_locked, a_frame_done, a_err_count);
        end
    endtask

    task automatic test_reset_midframe();
        run_until(15, 9);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (a_locked !== 1'b0 || a_frame_count !== 8'd0 || a_err_count !== 8'd0 ||
            a_meas_v_total !== 10'd0 || a_meas_h_total !== 10'd0) begin
            tests_failed++;
            $display("FAIL midreset_async: got locked=%b fc=%0d ec=%0d v=%0d h=%0d expected 0 0 0 0 0",
                     a_locked, a_frame_count, a_err_count, a_meas_v_total, a_meas_h_total);
        end
        repeat (3) @(negedge clk50);
        rst_n = 1'b1;
        run_vs(1);
        tests_run++;
        if (a_locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_first_vs: got locked=%b expected 0", a_locked);
        end
        run_vs(1);
        tests_run++;
        if (a_locked !== 1'b1 || a_err_count !== 8'd0 || a_frame_count !== 8'd1) begin
            tests_failed++;
            $display("FAIL midreset_relock: got locked=%b ec=%0d fc=%0d expected 1 0 1",
                     a_locked, a_err_count, a_frame_count);
        end
    endtask

    task automatic test_polarity();
        do_reset();
        run_vs(3);
        tests_run++;
        if (b_locked !== 1'b1 || b_frame_count !== 8'd2 || b_err_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL polarity_lock: got locked=%b fc=%0d ec=%0d expected 1 2 0",
                     b_locked, b_frame_count, b_err_count);
        end
        tests_run++;
        if (b_meas_h_total !== 10'(HT) || b_meas_v_total !== 10'(VT) ||
            b_meas_hs_width !== 10'(HSW) || b_meas_vs_width !== 10'(VSW)) begin
            tests_failed++;
            $display("FAIL polarity_meas: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                     b_meas_h_total, b_meas_v_total, b_meas_hs_width, b_meas_vs_width,
                     HT, VT, HSW, VSW);
        end
        tests_run++;
        if (b_frame_crc !== 16'h0000 || b_timing_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL polarity_crc: got crc=%h err=%b expected 0000 0", b_frame_crc, b_timing_err);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_nominal();
        test_signature();
        test_long_line();
        test_stall();
        test_reset_midframe();
        test_polarity();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
